// File: rtl/store_buffer.sv
// store_buffer
//   In-order write buffer between the core store path and the data memory
//   write port. Stores are accepted one per cycle while not full and drained
//   oldest-first whenever the memory port is granted.
//
//   Optional feature macro: STORE_BUF_FWD_EN
//     defined   : loads are looked up against all pending entries and the
//                 youngest matching store's data is forwarded.
//     undefined : no lookup hardware; ld_hit/ld_data are tied to 0 and the
//                 core must wait for empty before issuing loads.
//
//   Ports
//     clk, rstn          clock, synchronous active-low reset
//     st_valid/addr/data store request from core
//     st_ready           buffer not full (registered count only)
//     drain_en           memory write port granted this cycle
//     mem_WE/A/WD        data memory write port (A/WD zero when idle)
//     ld_addr            load address for forwarding lookup
//     ld_hit/ld_data     forwarding result (youngest match)
//     empty              no pending entries
//     err_ovf            sticky: store presented while full
module store_buffer #(
    parameter int DATA  = 32,
    parameter int ADDR  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            st_valid,
    input  logic [ADDR-1:0] st_addr,
    input  logic [DATA-1:0] st_data,
    output logic            st_ready,
    input  logic            drain_en,
    output logic            mem_WE,
    output logic [ADDR-1:0] mem_A,
    output logic [DATA-1:0] mem_WD,
    input  logic [ADDR-1:0] ld_addr,
    output logic            ld_hit,
    output logic [DATA-1:0] ld_data,
    output logic            empty,
    output logic            err_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_ovf_q, err_ovf_d;
    logic [ADDR-1:0] entry_addr_q [DEPTH];
    logic [DATA-1:0] entry_data_q [DEPTH];
    logic            push;
    logic            pop;

    // Full/empty come only from the registered count, so a full buffer
    // refuses a store even in a cycle where it is also draining.
    always_comb begin
        st_ready  = (count_q != FULL_CNT);
        empty     = (count_q == '0);
        push      = st_valid && st_ready;
        pop       = drain_en && !empty;

        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        err_ovf_d = err_ovf_q | (st_valid && !st_ready);

        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        mem_WE    = pop;
        mem_A     = pop ? entry_addr_q[rd_ptr_q] : '0;
        mem_WD    = pop ? entry_data_q[rd_ptr_q] : '0;
        err_ovf   = err_ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // Entry storage carries no reset; validity is implied by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr_q[wr_ptr_q] <= st_addr;
            entry_data_q[wr_ptr_q] <= st_data;
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Walk valid entries from oldest to youngest; a later match overrides an
    // earlier one, so the youngest matching store wins. The entry being
    // drained this cycle is still counted, a store being pushed is not.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (entry_addr_q[fwd_idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = entry_data_q[fwd_idx];
            end
        end
    end
`else
    logic unused_ld_addr;

    assign unused_ld_addr = ^ld_addr;
    assign ld_hit         = 1'b0;
    assign ld_data        = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        rstn;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        drain_en;
    logic        mem_WE;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        empty;
    logic        err_ovf;

    ent_t sb[$];
    logic m_err;
    int   vectors;
    int   miscompares;

    store_buffer #(.DATA(32), .ADDR(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ready (st_ready),
        .drain_en (drain_en),
        .mem_WE   (mem_WE),
        .mem_A    (mem_A),
        .mem_WD   (mem_WD),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .empty    (empty),
        .err_ovf  (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs just after a posedge and let them settle before sampling.
    task automatic set_in(input logic sv, input logic [31:0] a, input logic [31:0] d,
                          input logic de, input logic [31:0] la);
        st_valid = sv;
        st_addr  = a;
        st_data  = d;
        drain_en = de;
        ld_addr  = la;
        #2;
    endtask

    // Advance the reference model with the current inputs, then clock.
    task automatic clk_edge();
        int   pre;
        ent_t e;
        pre = sb.size();
        if (!rstn) begin
            sb.delete();
            m_err = 1'b0;
        end else begin
            if (st_valid && pre == DEPTH) m_err = 1'b1;
            if (drain_en && pre != 0) void'(sb.pop_front());
            if (st_valid && pre != DEPTH) begin
                e.a = st_addr;
                e.d = st_data;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        set_in(0, 0, 0, 0, 0);
        clk_edge();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        set_in(0, 0, 0, 0, 0);
        vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("FAIL reset_st_ready got=%b exp=1", st_ready); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", empty); end
        vectors++; if (mem_WE !== 1'b0) begin miscompares++; $display("FAIL reset_mem_WE got=%b exp=0", mem_WE); end
        vectors++; if (ld_hit !== 1'b0) begin miscompares++; $display("FAIL reset_ld_hit got=%b exp=0", ld_hit); end
        vectors++; if (ld_data !== 32'h0) begin miscompares++; $display("FAIL reset_ld_data got=%h exp=0", ld_data); end
        vectors++; if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_err_ovf got=%b exp=0", err_ovf); end
    endtask

    task automatic test_basic();
        do_reset();
        set_in(1, 32'd4, 32'h11, 0, 0); clk_edge();
        set_in(1, 32'd8, 32'h22, 0, 0); clk_edge();
        set_in(0, 0, 0, 0, 0);
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("FAIL basic_empty got=%b exp=0", empty); end
        vectors++; if (mem_WE !== 1'b0) begin miscompares++; $display("FAIL basic_noWE got=%b exp=0", mem_WE); end
        vectors++; if (sb.size() != 2) begin miscompares++; $display("FAIL basic_model_size got=%0d exp=2", sb.size()); end
        for (int k = 0; k < DEPTH + 2 && sb.size() > 0; k++) begin
            set_in(0, 0, 0, 1, 0);
            vectors++; if (mem_WE !== 1'b1) begin miscompares++; $display("FAIL basic_WE got=%b exp=1", mem_WE); end
            vectors++; if (mem_A !== sb[0].a) begin miscompares++; $display("FAIL basic_A got=%h exp=%h", mem_A, sb[0].a); end
            vectors++; if (mem_WD !== sb[0].d) begin miscompares++; $display("FAIL basic_WD got=%h exp=%h", mem_WD, sb[0].d); end
            clk_edge();
        end
        set_in(0, 0, 0, 1, 0);
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL basic_empty_end got=%b exp=1", empty); end
        vectors++; if (mem_WE !== 1'b0) begin miscompares++; $display("FAIL basic_WE_end got=%b exp=0", mem_WE); end
        vectors++; if (mem_A !== 32'h0) begin miscompares++; $display("FAIL basic_A_idle got=%h exp=0", mem_A); end
        clk_edge();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 32'h100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 0, 0);
            clk_edge();
        end
        set_in(1, 32'h200, 32'hDEAD, 0, 0);
        vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_st_ready got=%b exp=0", st_ready); end
        clk_edge();
        set_in(0, 0, 0, 0, 0);
        vectors++; if (err_ovf !== m_err) begin miscompares++; $display("FAIL ovf_err got=%b exp=%b", err_ovf, m_err); end
        for (int k = 0; k < DEPTH + 2 && sb.size() > 0; k++) begin
            set_in(0, 0, 0, 1, 0);
            vectors++; if (mem_A !== sb[0].a || mem_WD !== sb[0].d || mem_WE !== 1'b1)
                begin miscompares++; $display("FAIL ovf_drain got=%b/%h/%h exp=1/%h/%h", mem_WE, mem_A, mem_WD, sb[0].a, sb[0].d); end
            clk_edge();
        end
        set_in(0, 0, 0, 0, 0);
        vectors++; if (err_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_err_sticky got=%b exp=1", err_ovf); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL ovf_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 32'h300 + 32'(i), 32'h5A00 + 32'(i), 0, 0);
            clk_edge();
        end
        set_in(1, 32'h3FF, 32'h7777, 1, 0);
        vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("FAIL fpp_st_ready got=%b exp=0", st_ready); end
        vectors++; if (mem_WE !== 1'b1 || mem_A !== sb[0].a) begin miscompares++; $display("FAIL fpp_pop got=%b/%h exp=1/%h", mem_WE, mem_A, sb[0].a); end
        clk_edge();
        set_in(1, 32'h3FF, 32'h7777, 0, 0);
        vectors++; if (err_ovf !== 1'b1) begin miscompares++; $display("FAIL fpp_err got=%b exp=1", err_ovf); end
        vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("FAIL fpp_ready_after got=%b exp=1", st_ready); end
        clk_edge();
        for (int k = 0; k < DEPTH + 2 && sb.size() > 0; k++) begin
            set_in(0, 0, 0, 1, 0);
            vectors++; if (mem_A !== sb[0].a || mem_WD !== sb[0].d || mem_WE !== 1'b1)
                begin miscompares++; $display("FAIL fpp_drain got=%b/%h/%h exp=1/%h/%h", mem_WE, mem_A, mem_WD, sb[0].a, sb[0].d); end
            clk_edge();
        end
    endtask

    task automatic test_wrap();
        int pushes;
        logic sv;
        logic de;
        do_reset();
        pushes = 0;
        for (int c = 0; c < 40; c++) begin
            sv = (sb.size() < DEPTH);
            de = ($urandom_range(3) != 0);
            set_in(sv, $urandom, $urandom, de, 0);
            vectors++; if (st_ready !== (sb.size() != DEPTH)) begin miscompares++; $display("FAIL wrap_ready got=%b exp=%b", st_ready, sb.size() != DEPTH); end
            if (de && sb.size() > 0) begin
                vectors++; if (mem_A !== sb[0].a || mem_WD !== sb[0].d || mem_WE !== 1'b1)
                    begin miscompares++; $display("FAIL wrap_drain got=%b/%h/%h exp=1/%h/%h", mem_WE, mem_A, mem_WD, sb[0].a, sb[0].d); end
            end
            if (sv) pushes++;
            clk_edge();
        end
        for (int k = 0; k < DEPTH + 2 && sb.size() > 0; k++) begin
            set_in(0, 0, 0, 1, 0);
            vectors++; if (mem_A !== sb[0].a || mem_WD !== sb[0].d || mem_WE !== 1'b1)
                begin miscompares++; $display("FAIL wrap_tail got=%b/%h/%h exp=1/%h/%h", mem_WE, mem_A, mem_WD, sb[0].a, sb[0].d); end
            clk_edge();
        end
        set_in(0, 0, 0, 0, 0);
        vectors++; if (empty !== 1'b1 || pushes <= 2 * DEPTH) begin miscompares++; $display("FAIL wrap_end empty=%b pushes=%0d exp=1/>%0d", empty, pushes, 2 * DEPTH); end
        vectors++; if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL wrap_err got=%b exp=0", err_ovf); end
    endtask

    task automatic test_forward();
        do_reset();
        set_in(1, 32'd16, 32'hAA, 0, 0); clk_edge();
        set_in(1, 32'd16, 32'hBB, 0, 0); clk_edge();
        set_in(0, 0, 0, 0, 32'd16);
        vectors++; if (ld_hit !== FWD) begin miscompares++; $display("FAIL fwd_hit got=%b exp=%b", ld_hit, FWD); end
        vectors++; if (ld_data !== (FWD ? 32'hBB : 32'h0)) begin miscompares++; $display("FAIL fwd_young got=%h exp=%h", ld_data, FWD ? 32'hBB : 32'h0); end
        set_in(0, 0, 0, 0, 32'd20);
        vectors++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin miscompares++; $display("FAIL fwd_miss got=%b/%h exp=0/0", ld_hit, ld_data); end
        set_in(0, 0, 0, 1, 32'd16);
        vectors++; if (mem_A !== 32'd16 || mem_WD !== 32'hAA) begin miscompares++; $display("FAIL fwd_drain got=%h/%h exp=10/aa", mem_A, mem_WD); end
        vectors++; if (ld_data !== (FWD ? 32'hBB : 32'h0)) begin miscompares++; $display("FAIL fwd_during_drain got=%h exp=%h", ld_data, FWD ? 32'hBB : 32'h0); end
        clk_edge();
        set_in(0, 0, 0, 1, 32'd16);
        vectors++; if (ld_hit !== FWD || ld_data !== (FWD ? 32'hBB : 32'h0))
            begin miscompares++; $display("FAIL fwd_last_entry got=%b/%h exp=%b/%h", ld_hit, ld_data, FWD, FWD ? 32'hBB : 32'h0); end
        clk_edge();
        set_in(1, 32'd20, 32'hDD, 0, 32'd20);
        vectors++; if (ld_hit !== 1'b0) begin miscompares++; $display("FAIL fwd_same_cycle got=%b exp=0", ld_hit); end
        clk_edge();
        set_in(0, 0, 0, 0, 32'd20);
        vectors++; if (ld_hit !== FWD || ld_data !== (FWD ? 32'hDD : 32'h0))
            begin miscompares++; $display("FAIL fwd_next_cycle got=%b/%h exp=%b/%h", ld_hit, ld_data, FWD, FWD ? 32'hDD : 32'h0); end
        set_in(0, 0, 0, 1, 0);
        clk_edge();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, 32'h40 + 32'(i), 32'h9000 + 32'(i), 0, 0);
            clk_edge();
        end
        set_in(1, 32'h50, 32'h1, 0, 0); clk_edge();
        set_in(0, 0, 0, 1, 0); clk_edge();
        set_in(0, 0, 0, 0, 0);
        vectors++; if (err_ovf !== 1'b1 || sb.size() != 3) begin miscompares++; $display("FAIL mid_setup got=%b/%0d exp=1/3", err_ovf, sb.size()); end
        rstn = 1'b0;
        set_in(0, 0, 0, 1, 32'h42);
        clk_edge();
        rstn = 1'b1;
        set_in(0, 0, 0, 1, 32'h42);
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL mid_empty got=%b exp=1", empty); end
        vectors++; if (mem_WE !== 1'b0) begin miscompares++; $display("FAIL mid_WE got=%b exp=0", mem_WE); end
        vectors++; if (err_ovf !== 1'b0) begin miscompares++; $display("FAIL mid_err got=%b exp=0", err_ovf); end
        vectors++; if (ld_hit !== 1'b0) begin miscompares++; $display("FAIL mid_ld_hit got=%b exp=0", ld_hit); end
        clk_edge();
        set_in(0, 0, 0, 1, 0);
        vectors++; if (mem_WE !== 1'b0) begin miscompares++; $display("FAIL mid_WE_later got=%b exp=0", mem_WE); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_err       = 1'b0;
        rstn        = 1'b0;
        st_valid    = 1'b0;
        st_addr     = '0;
        st_data     = '0;
        drain_en    = 1'b0;
        ld_addr     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_forward();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer between the datapath's store path and the data memory write port.
- Accepts store requests (address, data) from the core at one per cycle.
- Drains them in order into data memory whenever the memory port is granted.
- Optionally forwards buffered store data to loads that hit a pending address, so loads never see stale memory.

Parameters:
- DATA, 32, data width in bits.
- ADDR, 32, address width in bits.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  reset; one clock, synchronous, active-low.
- st_valid  input  1  store request from core.
- st_addr  input  ADDR  store address.
- st_data  input  DATA  store data.
- st_ready  output  1  buffer can accept a store this cycle (not full).
- drain_en  input  1  memory write port granted to buffer this cycle.
- mem_WE  output  1  write enable to data memory.
- mem_A  output  ADDR  write address to data memory.
- mem_WD  output  DATA  write data to data memory.
- ld_addr  input  ADDR  load address for forwarding lookup.
- ld_hit  output  1  ld_addr matches a valid buffered entry.
- ld_data  output  DATA  data of youngest matching entry.
- empty  output  1  no valid entries.
- err_ovf  output  1  sticky: a store was presented while full.

Behaviour:
- Storage: DEPTH entries of {addr, data}; write pointer wr_ptr, read pointer rd_ptr, occupancy count (0..DEPTH, width clog2(DEPTH)+1).
- Pointers wrap modulo DEPTH.
- Reset (rstn=0 at posedge): wr_ptr=rd_ptr=0, count=0, err_ovf=0. Entry contents are don't-care; valid is derived from count.
  - Resulting outputs: st_ready=1, empty=1, mem_WE=0, ld_hit=0, ld_data=0.
- Reset mid-operation discards all pending stores; none are written to memory after reset.
- st_ready = (count != DEPTH), combinational from registered count. No same-cycle bypass: a full buffer never accepts, even if draining that cycle.
- Push: st_valid && st_ready at posedge → entry[wr_ptr] <= {st_addr, st_data}, wr_ptr++.
- Overflow: st_valid && !st_ready → store dropped, err_ovf <= 1 (sticky until reset).
- Pop/drain: mem_WE = drain_en && !empty, combinational.
  - mem_A and mem_WD are entry[rd_ptr] when mem_WE=1, else 0.
  - Memory captures the write at the same posedge as the pop (rd_ptr++).
- Simultaneous push and pop: count unchanged, both pointers advance. Legal at any occupancy except: full allows pop only; empty allows push only.
- Ordering: strict FIFO; duplicate addresses are kept as separate entries and drained oldest first.
- Latency: a store pushed at edge N can be drained at the earliest in cycle N+1, written at edge N+1.
- empty = (count == 0).
- Forwarding lookup (combinational):
  - Compare ld_addr against every valid entry (those between rd_ptr and wr_ptr).
  - Youngest match wins: ld_hit=1, ld_data=its data.
  - The entry being drained this cycle is still valid and forwardable.
  - A store being pushed in the same cycle is not visible to the lookup.
  - No match: ld_hit=0, ld_data=0.

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- Defined: forwarding comparators and mux as described.
- Undefined: no comparators are built; ld_hit and ld_data are tied to 0. The core must stall loads until empty=1. All other behaviour is identical.

Test Plan:
- Reset, then push {A=4,D=0x11}, {A=8,D=0x22} with drain_en=0 → after 2 edges count=2, empty=0, mem_WE=0. Raise drain_en → mem_WE=1 with A=4,D=0x11, then A=8,D=0x22; then empty=1.
- DEPTH=4, push 4 stores with drain_en=0 → st_ready=0. Push a 5th store → dropped, err_ovf=1. drain_en=1 for 4 cycles → the 4 original stores come out in order; err_ovf stays 1.
- Full buffer with drain_en=1 and st_valid=1 in the same cycle → pop occurs, push is not accepted, err_ovf=1. Next cycle st_ready=1 and the push is accepted.
- Push continuously across more than 2×DEPTH stores while draining → pointer wrap-around produces correct FIFO order and no lost entries.
- (FWD_EN) Push {A=16,D=0xAA}, then {A=16,D=0xBB}, then ld_addr=16 → ld_hit=1, ld_data=0xBB. ld_addr=20 → ld_hit=0, ld_data=0. Drain one entry → ld_data is still 0xBB.
- Pulse rstn=0 for one posedge with 3 entries pending and drain_en=1 → next cycle empty=1, mem_WE=0, err_ovf=0, ld_hit=0.
